store_buffer: RTL and testbench

- Small in-order FIFO of pending stores between the pipeline MEM stage and the data memory's single synchronous write port.
- Accepts one store per cycle from MEM and drains at most one entry per cycle into memory when granted.
- Loads read memory combinationally, and the block forwards the youngest buffered store to the same address so loads never see stale data.

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/sb_fwd_match.sv | 40 ++++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer.
//   ADDR_WIDTH / DATA_WIDTH : global memory bus widths
//   SB_DEPTH_DEFAULT        : default number of buffer entries
//   sb_entry_t              : address/data payload of one entry.
//                             Valid bits live in a separate vector so they
//                             alone can be reset while the payload is not.
package store_buffer_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector for store-to-load forwarding (combinational).
// Ports:
//   entries_i  : buffer payload array
//   valid_i    : per-entry valid bits
//   tail_i     : next allocation slot (youngest entry is tail_i-1)
//   ld_addr_i  : load address to match
//   hit_o      : some valid entry matches ld_addr_i
//   hit_data_o : data of the youngest matching entry
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t              entries_i [DEPTH],
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [PTR_W-1:0]       tail_i,
  input  logic [ADDR_WIDTH-1:0]  ld_addr_i,
  output logic                   hit_o,
  output logic [DATA_WIDTH-1:0]  hit_data_o
);

  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (tail) to the youngest (tail-1); the last
  // match overrides earlier ones, so the youngest store wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_i + PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the data memory's single
// synchronous write port, with youngest-store forwarding to loads.
// Optional build macro STORE_BUF_COALESCE_EN: a store to the same address
// as the youngest entry overwrites that entry instead of allocating.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   st_valid/st_ready         : store handshake from MEM
//   st_addr/st_data           : store payload
//   ld_addr/ld_data           : load address and forwarded/memory data
//   mem_read_address          : = ld_addr
//   mem_data_out              : memory async read data
//   wr_grant                  : memory write port available this cycle
//   mem_write_en/_address     : memory write of the head entry
//   mem_data_in               : head entry data
//   sb_empty, sb_count        : occupancy status
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int SB_PTR_W = $clog2(SB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  wr_grant,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  sb_empty,
  output logic [SB_PTR_W:0]     sb_count
);

  localparam logic [SB_PTR_W:0] DEPTH_C = (SB_PTR_W+1)'(SB_DEPTH);

  logic [SB_PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
  logic [SB_PTR_W:0]   count_q, count_d;
  logic [SB_DEPTH-1:0] valid_q, valid_d;
  sb_entry_t           ent_q [SB_DEPTH];

  logic full, drain, enq, alloc, coal_hit;
  logic fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign tail_m1 = tail_q - SB_PTR_W'(1);
  assign full    = (count_q == DEPTH_C);
  assign drain   = (count_q != '0) && wr_grant;

`ifdef STORE_BUF_COALESCE_EN
  // Merging into a head that is leaving this cycle would lose the new data.
  assign coal_hit = (count_q != '0) && (ent_q[tail_m1].addr == st_addr) &&
                    !((tail_m1 == head_q) && drain);
`else
  assign coal_hit = 1'b0;
`endif

  assign st_ready = !full || drain || coal_hit;
  assign enq      = st_valid && st_ready;
  assign alloc    = enq && !coal_hit;

  always_comb begin
    head_d  = head_q + SB_PTR_W'(drain);
    tail_d  = tail_q + SB_PTR_W'(alloc);
    count_d = count_q + (SB_PTR_W+1)'(alloc) - (SB_PTR_W+1)'(drain);
    valid_d = valid_q;
    // Clear before set: when full, head and tail alias and the new store
    // must leave the slot valid.
    if (drain) valid_d[head_q] = 1'b0;
    if (alloc) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_q[tail_q] <= '{addr: st_addr, data: st_data};
    end else if (enq) begin
      ent_q[tail_m1].data <= st_data;
    end
  end

  sb_fwd_match #(
    .DEPTH (SB_DEPTH),
    .PTR_W (SB_PTR_W)
  ) u_fwd (
    .entries_i  (ent_q),
    .valid_i    (valid_q),
    .tail_i     (tail_q),
    .ld_addr_i  (ld_addr),
    .hit_o      (fwd_hit),
    .hit_data_o (fwd_data)
  );

  assign mem_read_address  = ld_addr;
  assign ld_data           = fwd_hit ? fwd_data : mem_data_out;
  assign mem_write_en      = drain;
  assign mem_write_address = ent_q[head_q].addr;
  assign mem_data_in       = ent_q[head_q].data;
  assign sb_empty          = (count_q == '0);
  assign sb_count          = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(alloc && full && !drain));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(drain && (count_q == '0)));

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int D  = 4;
  localparam int PW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  st_valid, st_ready;
  logic [ADDR_WIDTH-1:0] st_addr, ld_addr, mem_read_address, mem_write_address;
  logic [DATA_WIDTH-1:0] st_data, mem_data_out, ld_data, mem_data_in;
  logic                  wr_grant, mem_write_en, sb_empty;
  logic [PW:0]           sb_count;

  store_buffer #(.SB_DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .ld_addr           (ld_addr),
    .mem_read_address  (mem_read_address),
    .mem_data_out      (mem_data_out),
    .ld_data           (ld_data),
    .wr_grant          (wr_grant),
    .mem_write_en      (mem_write_en),
    .mem_write_address (mem_write_address),
    .mem_data_in       (mem_data_in),
    .sb_empty          (sb_empty),
    .sb_count          (sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_pass  = 0;
  int  n_total = 0;

  // Model data memory: async read, sync write, low 8 address bits.
  logic [DATA_WIDTH-1:0] mem [256];
  bit mem_init_done = 1'b0;

  function automatic logic [31:0] init_val(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_write_en === 1'b1) begin
      mem[mem_write_address[7:0]] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_read_address[7:0]];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Write monitor: every memory write must match the next expected store.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                 mem_write_address, mem_data_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_write_address, mon_e.a);
        check("wr_data", mem_data_in, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, bit push);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (push) exp_q.push_back('{a: a, d: d});
  endtask

  task automatic wait_empty(string nm);
    int n = 0;
    while (sb_empty !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(nm, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = 32'hFF; wr_grant = 1'b0;
    #2;
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_wen", 32'(mem_write_en), 32'd0);
    check("rst_ready", 32'(st_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single store, immediate drain.
    wr_grant = 1'b1;
    store(32'h10, 32'hA5, 1'b1);
    tick();
    st_valid = 1'b0;
    #2;
    check("t1_wen", 32'(mem_write_en), 32'd1);
    tick();
    check("t1_empty", 32'(sb_empty), 32'd1);

    // Fill with grant low, then release; fifth store rides the first drain.
    wr_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      store(32'(i), 32'(i * 'h11), 1'b1);
      tick();
    end
    store(32'h05, 32'h55, 1'b0);
    #3;
    check("t2_ready_full", 32'(st_ready), 32'd0);
    check("t2_count_full", 32'(sb_count), 32'd4);
    tick();
    check("t2_count_hold", 32'(sb_count), 32'd4);
    wr_grant = 1'b1;
    exp_q.push_back('{a: 32'h05, d: 32'h55});
    #3;
    check("t2_ready_drain", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    check("t2_count_swap", 32'(sb_count), 32'd4);
    wait_empty("t2_drained");

    // Forwarding of the youngest store.
    wr_grant = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    store(32'h20, 32'h7, 1'b0);
`else
    store(32'h20, 32'h7, 1'b1);
`endif
    tick();
    store(32'h20, 32'h9, 1'b1);
    ld_addr = 32'h20;
    #3;
    check("t3_same_cycle", ld_data, 32'h7);
    tick();
    st_valid = 1'b0;
    #3;
    check("t3_youngest", ld_data, 32'h9);
`ifdef STORE_BUF_COALESCE_EN
    check("t3_count", 32'(sb_count), 32'd1);
`else
    check("t3_count", 32'(sb_count), 32'd2);
`endif
    ld_addr = 32'h21;
    #1;
    check("t3_miss", ld_data, 32'hC0DE_0021);
    tick();
    ld_addr  = 32'h20;
    wr_grant = 1'b1;
    #2;
    check("t3_fwd_drain", ld_data, 32'h9);
    wait_empty("t3_drained");
    check("t3_mem_load", ld_data, 32'h9);

    // Full buffer streaming at one store per cycle.
    wr_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 32'(i), 32'h1040 + 32'(i), 1'b1);
      tick();
    end
    wr_grant = 1'b1;
    for (int i = 4; i < 12; i++) begin
      store(32'h40 + 32'(i), 32'h1040 + 32'(i), 1'b1);
      #3;
      check("t4_ready", 32'(st_ready), 32'd1);
      check("t4_count", 32'(sb_count), 32'd4);
      tick();
    end
    st_valid = 1'b0;
    wait_empty("t4_drained");
    tick();
    for (int i = 0; i < 12; i++)
      check("t4_mem", mem[8'h40 + 8'(i)], 32'h1040 + 32'(i));

    // Reset with pending stores discards them.
    wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h60 + 32'(i), 32'hBAD0 + 32'(i), 1'b0);
      tick();
    end
    st_valid = 1'b0;
    check("t5_count", 32'(sb_count), 32'd3);
    #2;
    rst = 1'b1;
    wr_grant = 1'b1;
    #1;
    check("t5_empty", 32'(sb_empty), 32'd1);
    check("t5_wen", 32'(mem_write_en), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++)
      check("t5_mem", mem[8'h60 + 8'(i)], init_val('h60 + i));

    // Back-to-back stores to one address.
    wr_grant = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    store(32'h30, 32'h1, 1'b0);
`else
    store(32'h30, 32'h1, 1'b1);
`endif
    tick();
    store(32'h30, 32'h2, 1'b1);
    tick();
    st_valid = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    check("t6_count", 32'(sb_count), 32'd1);
`else
    check("t6_count", 32'(sb_count), 32'd2);
`endif
    wr_grant = 1'b1;
    wait_empty("t6_drained");
    tick();
    check("t6_mem", mem[8'h30], 32'h2);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
